// File: rtl/approx_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_add_pkg
// Purpose  : Shared mode encoding and default widths for the approximate adder
// Revision : 1.0
// ============================================================================
package approx_add_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    localparam int STAT_W_DEFAULT = 32;

endpackage : approx_add_pkg
`default_nettype wire

// File: rtl/approx_add_core.sv
`default_nettype none
// ============================================================================
// Module   : approx_add_core
// Purpose  : Combinational lower-part-OR adder: splits operands for the first
//            pipeline stage and rebuilds exact/approximate sums from that split
// Revision : 1.0
// ============================================================================
module approx_add_core
    import approx_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 2,
    parameter int LW    = (K > 0) ? K : 1,
    parameter int HW    = WIDTH - K
) (
    // Operand split, evaluated before the first register stage
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [LW-1:0]    ex_lo_o,
    output logic             ex_c_o,
    output logic [LW-1:0]    ap_lo_o,
    output logic             ap_c_o,
    output logic [HW-1:0]    a_hi_o,
    output logic [HW-1:0]    b_hi_o,
    // Final sums, evaluated from the registered split
    input  logic [LW-1:0]    ex_lo_i,
    input  logic             ex_c_i,
    input  logic [LW-1:0]    ap_lo_i,
    input  logic             ap_c_i,
    input  logic [HW-1:0]    a_hi_i,
    input  logic [HW-1:0]    b_hi_i,
    output logic [WIDTH:0]   exact_sum_o,
    output logic [WIDTH:0]   approx_sum_o
);

    logic [HW:0] hi_ex;
    logic [HW:0] hi_ap;

    assign a_hi_o = a_i[WIDTH-1:K];
    assign b_hi_o = b_i[WIDTH-1:K];

    assign hi_ex = {1'b0, a_hi_i} + {1'b0, b_hi_i} + (HW+1)'(ex_c_i);
    assign hi_ap = {1'b0, a_hi_i} + {1'b0, b_hi_i} + (HW+1)'(ap_c_i);

    generate
        if (K > 0) begin : g_lo
            logic [K:0] lo_full;

            assign lo_full      = {1'b0, a_i[K-1:0]} + {1'b0, b_i[K-1:0]};
            assign ex_lo_o      = lo_full[K-1:0];
            assign ex_c_o       = lo_full[K];
            // Low bits are OR-ed; only the top low-bit pair generates a carry
            assign ap_lo_o      = a_i[K-1:0] | b_i[K-1:0];
            assign ap_c_o       = a_i[K-1] & b_i[K-1];
            assign exact_sum_o  = {hi_ex, ex_lo_i};
            assign approx_sum_o = {hi_ap, ap_lo_i};
        end else begin : g_nolo
            assign ex_lo_o      = '0;
            assign ex_c_o       = 1'b0;
            assign ap_lo_o      = '0;
            assign ap_c_o       = 1'b0;
            assign exact_sum_o  = hi_ex;
            assign approx_sum_o = hi_ap;
        end
    endgenerate

endmodule : approx_add_core
`default_nettype wire

// File: rtl/approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_add_pipe
// Purpose  : Two-stage valid/ready pipeline around approx_add_core with
//            saturating error statistics on delivered approximate samples
// Revision : 1.0
// ============================================================================
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2,
    parameter int STAT_W      = STAT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    out_sum,
    output logic              out_mode,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_samples,
    output logic [STAT_W-1:0] stat_err_cnt,
    output logic [STAT_W-1:0] stat_err_sum,
    output logic [STAT_W-1:0] stat_err_max
);

    localparam int K  = APPROX_BITS;
    localparam int LW = (K > 0) ? K : 1;
    localparam int HW = WIDTH - K;
    localparam int EW = WIDTH + 1;
    localparam int AW = ((STAT_W > EW) ? STAT_W : EW) + 1;
    localparam logic [STAT_W-1:0] SAT_MAX = {STAT_W{1'b1}};

    // Core split outputs and rebuilt sums
    logic [LW-1:0]    ex_lo, ap_lo;
    logic             ex_c, ap_c;
    logic [HW-1:0]    a_hi, b_hi;
    logic [WIDTH:0]   exact_sum, approx_sum;

    // Stage 1
    logic             s1_valid_q, s1_valid_d;
    mode_e            s1_mode_q;
    logic [LW-1:0]    s1_ex_lo_q, s1_ap_lo_q;
    logic             s1_ex_c_q, s1_ap_c_q;
    logic [HW-1:0]    s1_a_hi_q, s1_b_hi_q;

    // Stage 2 / output
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH:0]   sum_q, sum_d;
    mode_e            mode_q;
    logic [WIDTH:0]   err_q, err_d;
    logic             ready_en_q;

    // Statistics
    logic [STAT_W-1:0] samples_q, samples_d;
    logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
    logic [STAT_W-1:0] err_sum_q, err_sum_d;
    logic [STAT_W-1:0] err_max_q, err_max_d;

    logic             s2_ready, in_xfer, s2_load, out_xfer;
    logic [WIDTH:0]   diff;
    logic [AW-1:0]    err_ext, sum_ext;

    approx_add_core #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_core (
        .a_i          (in_a),
        .b_i          (in_b),
        .ex_lo_o      (ex_lo),
        .ex_c_o       (ex_c),
        .ap_lo_o      (ap_lo),
        .ap_c_o       (ap_c),
        .a_hi_o       (a_hi),
        .b_hi_o       (b_hi),
        .ex_lo_i      (s1_ex_lo_q),
        .ex_c_i       (s1_ex_c_q),
        .ap_lo_i      (s1_ap_lo_q),
        .ap_c_i       (s1_ap_c_q),
        .a_hi_i       (s1_a_hi_q),
        .b_hi_i       (s1_b_hi_q),
        .exact_sum_o  (exact_sum),
        .approx_sum_o (approx_sum)
    );

    // in_ready depends only on registered state and out_ready, never on in_valid
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready;
        in_ready   = ready_en_q && (!s1_valid_q || s2_ready);
        in_xfer    = in_valid && in_ready;
        s2_load    = s2_ready && s1_valid_q;
        s1_valid_d = in_xfer || (s1_valid_q && !s2_ready);
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        out_xfer   = s2_valid_q && out_ready;
    end

    always_comb begin
        diff  = (approx_sum >= exact_sum) ? (approx_sum - exact_sum)
                                          : (exact_sum - approx_sum);
        err_d = (s1_mode_q == MODE_APPROX) ? diff : '0;
        sum_d = (s1_mode_q == MODE_APPROX) ? approx_sum : exact_sum;
    end

    // Exact samples carry err_q == 0, so they only ever bump the sample count
    always_comb begin
        samples_d = samples_q;
        err_cnt_d = err_cnt_q;
        err_sum_d = err_sum_q;
        err_max_d = err_max_q;
        err_ext   = AW'(err_q);
        sum_ext   = AW'(err_sum_q) + err_ext;
        if (stat_clear) begin
            samples_d = '0;
            err_cnt_d = '0;
            err_sum_d = '0;
            err_max_d = '0;
        end else if (out_xfer) begin
            samples_d = (samples_q == SAT_MAX) ? SAT_MAX : samples_q + STAT_W'(1);
            if (err_q != '0) begin
                err_cnt_d = (err_cnt_q == SAT_MAX) ? SAT_MAX : err_cnt_q + STAT_W'(1);
                err_sum_d = (sum_ext > AW'(SAT_MAX)) ? SAT_MAX : sum_ext[STAT_W-1:0];
                if (err_ext > AW'(err_max_q)) begin
                    err_max_d = (err_ext > AW'(SAT_MAX)) ? SAT_MAX : err_ext[STAT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_EXACT;
            s1_ex_lo_q <= '0;
            s1_ex_c_q  <= 1'b0;
            s1_ap_lo_q <= '0;
            s1_ap_c_q  <= 1'b0;
            s1_a_hi_q  <= '0;
            s1_b_hi_q  <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            mode_q     <= MODE_EXACT;
            err_q      <= '0;
            samples_q  <= '0;
            err_cnt_q  <= '0;
            err_sum_q  <= '0;
            err_max_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_xfer) begin
                s1_mode_q  <= mode_e'(in_mode);
                s1_ex_lo_q <= ex_lo;
                s1_ex_c_q  <= ex_c;
                s1_ap_lo_q <= ap_lo;
                s1_ap_c_q  <= ap_c;
                s1_a_hi_q  <= a_hi;
                s1_b_hi_q  <= b_hi;
            end
            if (s2_load) begin
                sum_q  <= sum_d;
                mode_q <= s1_mode_q;
                err_q  <= err_d;
            end
            samples_q <= samples_d;
            err_cnt_q <= err_cnt_d;
            err_sum_q <= err_sum_d;
            err_max_q <= err_max_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_sum      = sum_q;
    assign out_mode     = mode_q;
    assign stat_samples = samples_q;
    assign stat_err_cnt = err_cnt_q;
    assign stat_err_sum = err_sum_q;
    assign stat_err_max = err_max_q;

endmodule : approx_add_pipe
`default_nettype wire

// File: tb/tb_approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_add_pipe
// Purpose  : Directed self-checking bench for approx_add_pipe (WIDTH=8, K=2)
// Revision : 1.0
// ============================================================================
module tb_approx_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_mode, out_ready, stat_clear;
    logic [7:0]  in_a, in_b;
    logic        in_ready, out_valid, out_mode;
    logic [8:0]  out_sum;
    logic [31:0] samples, err_cnt, err_sum, err_max;
    logic        in_ready4, out_valid4, out_mode4;
    logic [8:0]  out_sum4;
    logic [3:0]  samples4, err_cnt4, err_sum4, err_max4;

    int n_checks = 0;
    int n_pass   = 0;

    // Directed vectors with hand-computed results (K=2 lower-part OR)
    logic [7:0] va [8] = '{8'd3, 8'd3, 8'd2, 8'd5, 8'd255, 8'd200, 8'd128, 8'd15};
    logic [7:0] vb [8] = '{8'd1, 8'd1, 8'd2, 8'd6, 8'd255, 8'd100, 8'd128, 8'd1};
    logic       vm [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [8:0] ve [8] = '{9'd3, 9'd4, 9'd6, 9'd11, 9'd511, 9'd300, 9'd256, 9'd15};

    always #5 clk = ~clk;

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(2), .STAT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_mode(out_mode),
        .stat_clear(stat_clear), .stat_samples(samples), .stat_err_cnt(err_cnt),
        .stat_err_sum(err_sum), .stat_err_max(err_max)
    );

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(2), .STAT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid4),
        .out_ready(out_ready), .out_sum(out_sum4), .out_mode(out_mode4),
        .stat_clear(stat_clear), .stat_samples(samples4), .stat_err_cnt(err_cnt4),
        .stat_err_sum(err_sum4), .stat_err_max(err_max4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats;
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
    endtask

    task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic m);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_sum !== 9'd0 || out_mode !== 1'b0) $display("FAIL reset_out_data got %0d/%b want 0/0", out_sum, out_mode); else n_pass++;
        n_checks++; if ((samples | err_cnt | err_sum | err_max) !== 32'd0) $display("FAIL reset_stats got %0d %0d %0d %0d want 0", samples, err_cnt, err_sum, err_max); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL release_in_ready_early got %b want 0", in_ready); else n_pass++;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_approx_basic;
        clear_stats();
        send_one(8'd3, 8'd1, 1'b1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_latency1 out_valid got %b want 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_sum !== 9'd3 || out_mode !== 1'b1)
            $display("FAIL basic_result got v=%b sum=%0d m=%b want 1/3/1", out_valid, out_sum, out_mode); else n_pass++;
        tick();
        n_checks++; if (samples !== 32'd1 || err_cnt !== 32'd1 || err_sum !== 32'd1 || err_max !== 32'd1)
            $display("FAIL basic_stats got %0d %0d %0d %0d want 1 1 1 1", samples, err_cnt, err_sum, err_max); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_drained got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_exact_vs_approx;
        clear_stats();
        send_one(8'd255, 8'd255, 1'b1);
        tick();
        n_checks++; if (out_sum !== 9'd511 || out_mode !== 1'b1) $display("FAIL max_approx got %0d/%b want 511/1", out_sum, out_mode); else n_pass++;
        tick();
        send_one(8'd255, 8'd255, 1'b0);
        tick();
        n_checks++; if (out_sum !== 9'd510 || out_mode !== 1'b0) $display("FAIL max_exact got %0d/%b want 510/0", out_sum, out_mode); else n_pass++;
        tick();
        n_checks++; if (samples !== 32'd2 || err_cnt !== 32'd1 || err_sum !== 32'd1 || err_max !== 32'd1)
            $display("FAIL exact_no_err_stats got %0d %0d %0d %0d want 2 1 1 1", samples, err_cnt, err_sum, err_max); else n_pass++;
    endtask

    task automatic test_back_to_back;
        clear_stats();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            if (c < 8) begin
                in_a = va[c]; in_b = vb[c]; in_mode = vm[c];
            end
            #1;
            if (c >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_sum !== ve[c-2] || out_mode !== vm[c-2])
                    $display("FAIL b2b_sample%0d got v=%b sum=%0d m=%b want 1/%0d/%b", c-2, out_valid, out_sum, out_mode, ve[c-2], vm[c-2]);
                else n_pass++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (samples !== 32'd8 || err_cnt !== 32'd4 || err_sum !== 32'd5 || err_max !== 32'd2)
            $display("FAIL b2b_stats got %0d %0d %0d %0d want 8 4 5 2", samples, err_cnt, err_sum, err_max); else n_pass++;
    endtask

    task automatic test_stall;
        int tx = 0;
        int rx = 0;
        logic stalled = 1'b0;
        logic [8:0] hold_sum = '0;
        logic hold_mode = 1'b0;
        clear_stats();
        for (int c = 0; c < 80 && rx < 8; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            in_valid  = (tx < 8);
            if (tx < 8) begin
                in_a = va[tx]; in_b = vb[tx]; in_mode = vm[tx];
            end
            #1;
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_sum !== hold_sum || out_mode !== hold_mode)
                    $display("FAIL stall_hold cyc%0d got v=%b sum=%0d want 1/%0d", c, out_valid, out_sum, hold_sum);
                else n_pass++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (out_sum !== ve[rx] || out_mode !== vm[rx])
                    $display("FAIL stall_order idx%0d got %0d/%b want %0d/%b", rx, out_sum, out_mode, ve[rx], vm[rx]);
                else n_pass++;
                rx++;
            end
            stalled   = (out_valid === 1'b1) && !out_ready;
            hold_sum  = out_sum;
            hold_mode = out_mode;
            if (in_valid && in_ready === 1'b1) tx++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (rx != 8) $display("FAIL stall_delivered got %0d want 8", rx); else n_pass++;
        n_checks++; if (samples !== 32'd8) $display("FAIL stall_samples got %0d want 8", samples); else n_pass++;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b0 || samples !== 32'd8) $display("FAIL stall_no_dup got v=%b samples=%0d want 0/8", out_valid, samples); else n_pass++;
    endtask

    task automatic test_clear;
        clear_stats();
        out_ready = 1'b1;
        send_one(8'd2, 8'd2, 1'b1);
        repeat (2) tick();
        n_checks++; if (err_sum !== 32'd2 || err_max !== 32'd2) $display("FAIL clear_pre got %0d/%0d want 2/2", err_sum, err_max); else n_pass++;
        out_ready = 1'b0;
        send_one(8'd3, 8'd1, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_sum !== 9'd3) $display("FAIL clear_held got %b/%0d want 1/3", out_valid, out_sum); else n_pass++;
        out_ready  = 1'b1;
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        n_checks++; if ((samples | err_cnt | err_sum | err_max) !== 32'd0)
            $display("FAIL clear_wins got %0d %0d %0d %0d want 0", samples, err_cnt, err_sum, err_max); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL clear_drained got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_saturation;
        clear_stats();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = 8'd3; in_b = 8'd1; in_mode = 1'b1;
        repeat (20) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (err_sum4 !== 4'd15) $display("FAIL sat_err_sum got %0d want 15", err_sum4); else n_pass++;
        n_checks++; if (samples4 !== 4'd15 || err_cnt4 !== 4'd15 || err_max4 !== 4'd1)
            $display("FAIL sat_other got %0d %0d %0d want 15 15 1", samples4, err_cnt4, err_max4); else n_pass++;
        n_checks++; if (samples !== 32'd20 || err_sum !== 32'd20) $display("FAIL sat_wide got %0d/%0d want 20/20", samples, err_sum); else n_pass++;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_mode = 1'b1;
        tick();
        in_a = 8'd3; in_b = 8'd1;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre got %b want 1", out_valid); else n_pass++;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 9'd0)
            $display("FAIL mid_async got v=%b r=%b sum=%0d want 0/0/0", out_valid, in_ready, out_sum); else n_pass++;
        n_checks++; if ((samples | err_cnt | err_sum | err_max) !== 32'd0 || samples4 !== 4'd0)
            $display("FAIL mid_stats got %0d %0d %0d %0d want 0", samples, err_cnt, err_sum, err_max); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL mid_release got r=%b v=%b want 1/0", in_ready, out_valid); else n_pass++;
        send_one(8'd5, 8'd6, 1'b1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_lat1 got %b want 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_sum !== 9'd11 || out_mode !== 1'b1)
            $display("FAIL mid_first got v=%b sum=%0d want 1/11", out_valid, out_sum); else n_pass++;
        tick();
        n_checks++; if (samples !== 32'd1 || err_cnt !== 32'd0 || out_valid !== 1'b0)
            $display("FAIL mid_after got samples=%0d cnt=%0d v=%b want 1/0/0", samples, err_cnt, out_valid); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
        out_ready = 1'b1; stat_clear = 1'b0;
        test_reset();
        test_approx_basic();
        test_exact_vs_approx();
        test_back_to_back();
        test_stall();
        test_clear();
        test_saturation();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_approx_add_pipe
`default_nettype wire
